// File: rtl/parity_mem_writer.sv
// rtl/parity_mem_writer.sv - burst writer with even-parity store and read-back verify/retry
//
// Accepts a burst of words on a valid/ready stream, writes each word plus its
// parity bit into a parity-protected memory port, reads it back and verifies
// data and parity. A failing word is rewritten up to MAX_RETRY more times
// before the burst is aborted with an error report.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               begin a burst (honoured only when idle)
//   base_addr           first write address, sampled with start
//   burst_len           words in burst minus one, sampled with start
//   in_valid, in_data   input word stream
//   in_ready            writer accepts in_data this cycle
//   mem_we, mem_re      memory write / read strobes
//   mem_addr            memory address
//   mem_wdata, mem_wpar write data and its parity bit
//   mem_rdata, mem_rpar read data and stored parity, valid cycle after mem_re
//   busy, done          activity flag and end-of-burst pulse
//   write_error         sticky abort flag, cleared by next accepted start
//   err_addr            address of the word that exhausted its retries
//   words_written       words verified good in the current burst
module parity_mem_writer #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] burst_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wpar,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rpar,
    output logic              busy,
    output logic              done,
    output logic              write_error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   words_written
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W:0]   ONE_W = 1;
    localparam logic [RW-1:0]     ONE_R = 1;
    localparam logic [RW-1:0]     RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] hold;
    logic [RW-1:0]     retry;
    logic              check_pass;
    logic              retry_left;

    // A word is good only if data matches, stored parity matches the intended
    // parity, and the returned pair is self-consistent.
    always_comb begin
        check_pass = (mem_rdata == hold) && (mem_rpar == ^hold) && ((^mem_rdata) == mem_rpar);
        retry_left = (retry < RETRY_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_WRITE;
            end
            S_WRITE: begin
                mem_we   = 1'b1;
                state_nx = S_READ;
            end
            S_READ: begin
                mem_re   = 1'b1;
                state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (check_pass) begin
                    state_nx = (remaining == '0) ? S_DONE : S_WAIT_DATA;
                end else begin
                    state_nx = retry_left ? S_WRITE : S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr      <= '0;
            remaining     <= '0;
            hold          <= '0;
            retry         <= '0;
            write_error   <= 1'b0;
            err_addr      <= '0;
            words_written <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr      <= base_addr;
                        remaining     <= burst_len;
                        write_error   <= 1'b0;
                        err_addr      <= '0;
                        words_written <= '0;
                    end
                end
                S_WAIT_DATA: begin
                    if (in_valid) begin
                        hold  <= in_data;
                        retry <= '0;
                    end
                end
                S_CHECK: begin
                    if (check_pass) begin
                        words_written <= words_written + ONE_W;
                        if (remaining != '0) begin
                            remaining <= remaining - ONE_A;
                            cur_addr  <= cur_addr + ONE_A;
                        end
                    end else if (retry_left) begin
                        retry <= retry + ONE_R;
                    end else begin
                        write_error <= 1'b1;
                        err_addr    <= cur_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and data come straight from registers that only move on state
    // transitions, so they are stable for the whole WRITE/READ cycles.
    assign mem_addr  = cur_addr;
    assign mem_wdata = hold;
    assign mem_wpar  = ^hold;

endmodule

// File: tb/tb_parity_mem_writer.sv
// tb/tb_parity_mem_writer.sv - self-checking bench for parity_mem_writer
module tb_parity_mem_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] base_addr;
    logic [3:0] burst_len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic       mem_re;
    logic [3:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       mem_wpar;
    logic [3:0] mem_rdata;
    logic       mem_rpar;
    logic       busy;
    logic       done;
    logic       write_error;
    logic [3:0] err_addr;
    logic [4:0] words_written;

    parity_mem_writer #(.ADDR_W(4), .DATA_W(4), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wpar(mem_wpar),
        .mem_rdata(mem_rdata), .mem_rpar(mem_rpar), .busy(busy), .done(done),
        .write_error(write_error), .err_addr(err_addr),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Memory model with fault injection
    logic [4:0] mem [16];
    int         reads_of [16];
    logic       trans_en = 1'b0;
    logic [3:0] trans_addr = 4'd0;
    int         trans_at = 0;
    logic       bad_en = 1'b0;
    logic [3:0] bad_addr = 4'd0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= {mem_wpar, mem_wdata};
        if (mem_re) begin
            mem_rdata <= mem[mem_addr][3:0] ^
                ((trans_en && mem_addr == trans_addr && reads_of[mem_addr] == trans_at) ? 4'b0001 : 4'b0000);
            mem_rpar  <= mem[mem_addr][4] ^ (bad_en && mem_addr == bad_addr);
            reads_of[mem_addr] <= reads_of[mem_addr] + 1;
        end
    end

    // Monitor: records observed writes, in_ready cycles and done pulses
    int         cyc = 0;
    int         done_cnt = 0;
    logic [8:0] obs_q [$];
    int         rdy_q [$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_we) obs_q.push_back({mem_addr, mem_wdata, mem_wpar});
        if (in_ready) rdy_q.push_back(cyc);
        if (done) done_cnt++;
    end

    logic [8:0] exp_q [$];
    logic [8:0] e;
    int         obs_idx = 0;
    int         rdy_idx = 0;
    int         checks = 0;
    int         failures = 0;
    int         timeouts = 0;
    int         lat;

    task automatic do_start(input logic [3:0] b, input logic [3:0] l);
        start = 1'b1; base_addr = b; burst_len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one word after 'stall' idle cycles; returns at the negedge after the handshake.
    task automatic push_word(input logic [3:0] d, input int stall);
        int n;
        in_valid = 1'b0;
        repeat (stall) @(negedge clk);
        in_valid = 1'b1; in_data = d; n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            timeouts++;
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        lat = 1;
        while (!done && lat < 60) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0;
        base_addr = 4'd0; burst_len = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_re, mem_addr, mem_wdata, mem_wpar, busy, done,
             write_error, err_addr, words_written} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs: got=%h exp=0", {in_ready, mem_we, mem_re, mem_addr, mem_wdata,
                     mem_wpar, busy, done, write_error, err_addr, words_written});
        end
        reset = 1'b0;
        @(negedge clk);
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
    endtask

    task automatic test_single_write();
        timeouts = 0;
        do_start(4'd5, 4'd0);
        exp_q.push_back({4'd5, 4'b1011, 1'b1});
        push_word(4'b1011, 0);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wpar} !== {1'b1, 4'd5, 4'b1011, 1'b1}) begin
            failures++;
            $display("FAIL single_we_latency: got=%h exp=%h", {mem_we, mem_addr, mem_wdata, mem_wpar},
                     {1'b1, 4'd5, 4'b1011, 1'b1});
        end
        wait_done();
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL single_done_latency: got=%0d exp=4", lat); end
        checks++;
        if ({words_written, write_error} !== {5'd1, 1'b0}) begin
            failures++; $display("FAIL single_status: ww=%0d err=%b exp ww=1 err=0", words_written, write_error);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin failures++; $display("FAIL single_done_pulse: done=%b busy=%b exp 0 0", done, busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_idx >= obs_q.size() || obs_q[obs_idx] !== e) begin
                failures++; $display("FAIL single_sb: got=%h exp=%h", (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 9'h0, e);
            end
            obs_idx++;
        end
        checks++;
        if (obs_idx != obs_q.size() || timeouts != 0) begin
            failures++; $display("FAIL single_extra: writes=%0d exp=%0d timeouts=%0d", obs_q.size(), obs_idx, timeouts);
        end
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
    endtask

    task automatic test_wrap();
        logic [3:0] d [4];
        d[0] = 4'b0010; d[1] = 4'b1110; d[2] = 4'b0000; d[3] = 4'b1010;
        timeouts = 0;
        do_start(4'd14, 4'd3);
        exp_q.push_back({4'd14, 4'b0010, 1'b1});
        exp_q.push_back({4'd15, 4'b1110, 1'b1});
        exp_q.push_back({4'd0,  4'b0000, 1'b0});
        exp_q.push_back({4'd1,  4'b1010, 1'b0});
        for (int i = 0; i < 4; i++) push_word(d[i], 0);
        wait_done();
        checks++;
        if ({done, words_written, write_error} !== {1'b1, 5'd4, 1'b0}) begin
            failures++; $display("FAIL wrap_status: done=%b ww=%0d err=%b exp 1 4 0", done, words_written, write_error);
        end
        checks++;
        if (rdy_q.size() - rdy_idx != 4) begin
            failures++; $display("FAIL wrap_ready_count: got=%0d exp=4", rdy_q.size() - rdy_idx);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rdy_q[rdy_idx + i] - rdy_q[rdy_idx + i - 1] != 4) begin
                    failures++; $display("FAIL wrap_ready_gap: got=%0d exp=4", rdy_q[rdy_idx + i] - rdy_q[rdy_idx + i - 1]);
                end
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_idx >= obs_q.size() || obs_q[obs_idx] !== e) begin
                failures++; $display("FAIL wrap_sb: got=%h exp=%h", (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 9'h0, e);
            end
            obs_idx++;
        end
        @(negedge clk);
        checks++;
        if (obs_idx != obs_q.size() || timeouts != 0) begin
            failures++; $display("FAIL wrap_extra: writes=%0d exp=%0d timeouts=%0d", obs_q.size(), obs_idx, timeouts);
        end
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
    endtask

    task automatic test_transient();
        timeouts = 0;
        trans_addr = 4'd3; trans_at = reads_of[3]; trans_en = 1'b1;
        do_start(4'd2, 4'd2);
        exp_q.push_back({4'd2, 4'b0110, 1'b0});
        exp_q.push_back({4'd3, 4'b1001, 1'b0});
        exp_q.push_back({4'd3, 4'b1001, 1'b0});
        exp_q.push_back({4'd4, 4'b0111, 1'b1});
        push_word(4'b0110, 0);
        push_word(4'b1001, 0);
        push_word(4'b0111, 0);
        wait_done();
        checks++;
        if ({done, words_written, write_error} !== {1'b1, 5'd3, 1'b0}) begin
            failures++; $display("FAIL transient_status: done=%b ww=%0d err=%b exp 1 3 0", done, words_written, write_error);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_idx >= obs_q.size() || obs_q[obs_idx] !== e) begin
                failures++; $display("FAIL transient_sb: got=%h exp=%h", (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 9'h0, e);
            end
            obs_idx++;
        end
        @(negedge clk);
        checks++;
        if (obs_idx != obs_q.size() || timeouts != 0) begin
            failures++; $display("FAIL transient_extra: writes=%0d exp=%0d timeouts=%0d", obs_q.size(), obs_idx, timeouts);
        end
        trans_en = 1'b0;
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
    endtask

    task automatic test_persistent();
        int dc;
        timeouts = 0;
        bad_addr = 4'd7; bad_en = 1'b1;
        dc = done_cnt;
        do_start(4'd6, 4'd3);
        exp_q.push_back({4'd6, 4'b0101, 1'b0});
        for (int i = 0; i < 3; i++) exp_q.push_back({4'd7, 4'b1100, 1'b0});
        push_word(4'b0101, 0);
        push_word(4'b1100, 0);
        wait_done();
        checks++;
        if ({done, write_error, err_addr, words_written} !== {1'b1, 1'b1, 4'd7, 5'd1}) begin
            failures++; $display("FAIL persist_status: done=%b err=%b ea=%0d ww=%0d exp 1 1 7 1",
                                 done, write_error, err_addr, words_written);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({write_error, err_addr, words_written, busy, in_ready} !== {1'b1, 4'd7, 5'd1, 1'b0, 1'b0}
            || done_cnt != dc + 1) begin
            failures++; $display("FAIL persist_sticky: err=%b ea=%0d ww=%0d busy=%b dones=%0d exp 1 7 1 0 %0d",
                                 write_error, err_addr, words_written, busy, done_cnt - dc, 1);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_idx >= obs_q.size() || obs_q[obs_idx] !== e) begin
                failures++; $display("FAIL persist_sb: got=%h exp=%h", (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 9'h0, e);
            end
            obs_idx++;
        end
        checks++;
        if (obs_idx != obs_q.size() || timeouts != 0) begin
            failures++; $display("FAIL persist_extra: writes=%0d exp=%0d timeouts=%0d", obs_q.size(), obs_idx, timeouts);
        end
        bad_en = 1'b0;
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
    endtask

    task automatic test_stall_start();
        int nw;
        timeouts = 0;
        do_start(4'd9, 4'd1);
        checks++;
        if ({write_error, err_addr, words_written} !== 10'd0) begin
            failures++; $display("FAIL stall_start_clear: err=%b ea=%0d ww=%0d exp 0 0 0", write_error, err_addr, words_written);
        end
        nw = obs_q.size();
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != nw || {in_ready, busy} !== 2'b11) begin
            failures++; $display("FAIL stall_no_write: writes=%0d exp=%0d ready=%b busy=%b", obs_q.size(), nw, in_ready, busy);
        end
        exp_q.push_back({4'd9,  4'b0011, 1'b0});
        exp_q.push_back({4'd10, 4'b1111, 1'b0});
        push_word(4'b0011, 0);
        start = 1'b1; base_addr = 4'd0; burst_len = 4'd0;
        @(negedge clk);
        start = 1'b0;
        push_word(4'b1111, 0);
        wait_done();
        checks++;
        if ({done, words_written, write_error} !== {1'b1, 5'd2, 1'b0}) begin
            failures++; $display("FAIL stall_status: done=%b ww=%0d err=%b exp 1 2 0", done, words_written, write_error);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_idx >= obs_q.size() || obs_q[obs_idx] !== e) begin
                failures++; $display("FAIL stall_sb: got=%h exp=%h", (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 9'h0, e);
            end
            obs_idx++;
        end
        @(negedge clk);
        checks++;
        if (obs_idx != obs_q.size() || timeouts != 0) begin
            failures++; $display("FAIL stall_extra: writes=%0d exp=%0d timeouts=%0d", obs_q.size(), obs_idx, timeouts);
        end
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
    endtask

    task automatic test_full_burst();
        logic [3:0] d;
        timeouts = 0;
        do_start(4'd0, 4'd15);
        for (int i = 0; i < 16; i++) begin
            d = 4'(i * 7 + 3);
            exp_q.push_back({4'(i), d, ^d});
            push_word(d, 0);
        end
        wait_done();
        checks++;
        if ({done, words_written, write_error} !== {1'b1, 5'd16, 1'b0}) begin
            failures++; $display("FAIL full_status: done=%b ww=%0d err=%b exp 1 16 0", done, words_written, write_error);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_idx >= obs_q.size() || obs_q[obs_idx] !== e) begin
                failures++; $display("FAIL full_sb: got=%h exp=%h", (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 9'h0, e);
            end
            obs_idx++;
        end
        @(negedge clk);
        checks++;
        if (obs_idx != obs_q.size() || timeouts != 0) begin
            failures++; $display("FAIL full_extra: writes=%0d exp=%0d timeouts=%0d", obs_q.size(), obs_idx, timeouts);
        end
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
    endtask

    task automatic test_reset_mid();
        int dc;
        timeouts = 0;
        do_start(4'd12, 4'd2);
        exp_q.push_back({4'd12, 4'b1000, 1'b1});
        push_word(4'b1000, 0);
        @(negedge clk);
        checks++;
        if (mem_re !== 1'b1) begin failures++; $display("FAIL rstmid_read: mem_re=%b exp=1", mem_re); end
        reset = 1'b1;
        dc = done_cnt;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_re, mem_addr, mem_wdata, mem_wpar, busy, done,
             write_error, err_addr, words_written} !== 24'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got=%h exp=0", {in_ready, mem_we, mem_re, mem_addr, mem_wdata,
                     mem_wpar, busy, done, write_error, err_addr, words_written});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != dc || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_done: dones=%0d exp=0 busy=%b", done_cnt - dc, busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_idx >= obs_q.size() || obs_q[obs_idx] !== e) begin
                failures++; $display("FAIL rstmid_sb: got=%h exp=%h", (obs_idx < obs_q.size()) ? obs_q[obs_idx] : 9'h0, e);
            end
            obs_idx++;
        end
        checks++;
        if (obs_idx != obs_q.size() || timeouts != 0) begin
            failures++; $display("FAIL rstmid_extra: writes=%0d exp=%0d timeouts=%0d", obs_q.size(), obs_idx, timeouts);
        end
        obs_idx = obs_q.size(); rdy_idx = rdy_q.size();
        test_single_write();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wrap();
        test_transient();
        test_persistent();
        test_stall_start();
        test_full_burst();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
